// File: rtl/multdiv_issue_ctrl_pkg.sv
// Shared definitions for the execute-stage mult/div issue controller:
// opcodes, FSM state encoding and writeback exception codes.
package multdiv_issue_ctrl_pkg;

  localparam logic [4:0] OP_MULT = 5'd6;
  localparam logic [4:0] OP_DIV  = 5'd7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    EXC_NONE    = 2'd0,
    EXC_MULT    = 2'd1,
    EXC_DIV     = 2'd2,
    EXC_TIMEOUT = 2'd3
  } exc_e;

  function automatic logic is_md_op(input logic [4:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/multdiv_issue_ctrl_md_timeout_counter.sv
// Wait-cycle counter shared by the WAIT and DRAIN states; hit flags the
// cycle in which the count has reached TIMEOUT.
module md_timeout_counter #(
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             hit
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;
  assign hit   = (r_count == LIMIT);

endmodule

// File: rtl/multdiv_issue_ctrl.sv
// Execute-stage sequencer for the multi-cycle mult/div unit: issues start
// pulses, stalls the pipeline, and hands the result or exception to writeback.
module multdiv_issue_ctrl
  import multdiv_issue_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ex_valid,
  input  logic [4:0]       ex_opcode,
  input  logic [4:0]       ex_rd,
  input  logic             flush,
  input  logic [31:0]      md_result,
  input  logic             md_ready,
  input  logic             md_exception,
  output logic             md_mult,
  output logic             md_div,
  output logic             stall,
  output logic             busy,
  output logic             wb_valid,
  output logic [4:0]       wb_rd,
  output logic [31:0]      wb_data,
  output logic [1:0]       wb_exc_code,
  output logic [2:0]       dbg_state,
  output logic [CNT_W-1:0] dbg_wait_cnt
);

  // Handshake: start pulses are single-cycle requests with no ready; the unit
  // answers with md_ready, which is only honoured in WAIT and DRAIN.
  state_e      r_state, w_next;
  logic        r_op_div;
  logic [4:0]  r_rd;
  logic        r_md_mult, r_md_div;
  logic        r_wb_valid;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;
  logic [1:0]  r_wb_exc;

  logic        w_is_md, w_accept, w_issue, w_op_div;
  logic        w_cap_en;
  logic [1:0]  w_cap_exc;
  logic [31:0] w_cap_data;
  logic        w_cnt_clear, w_cnt_en, w_hit;
  logic [CNT_W-1:0] w_count;

  assign w_is_md  = is_md_op(ex_opcode);
  assign w_op_div = (ex_opcode == OP_DIV);
  assign w_accept = ex_valid & w_is_md & ~flush;
  assign w_issue  = (r_state == ST_IDLE) & w_accept;

  assign w_cnt_clear = (r_state == ST_START);
  assign w_cnt_en    = (r_state == ST_WAIT) | (r_state == ST_DRAIN);

  md_timeout_counter #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timeout (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (w_cnt_clear),
    .enable  (w_cnt_en),
    .count   (w_count),
    .hit     (w_hit)
  );

  always_comb begin
    w_next     = r_state;
    w_cap_en   = 1'b0;
    w_cap_exc  = EXC_NONE;
    w_cap_data = '0;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next = ST_START;
      ST_START: w_next = flush ? ST_DRAIN : ST_WAIT;
      ST_WAIT: begin
        // A flush that coincides with completion has nothing left to drain.
        if (flush) begin
          w_next = (md_ready | w_hit) ? ST_IDLE : ST_DRAIN;
        end else if (md_ready) begin
          w_next   = ST_DONE;
          w_cap_en = 1'b1;
          if (md_exception) w_cap_exc = r_op_div ? EXC_DIV : EXC_MULT;
          else              w_cap_data = md_result;
        end else if (w_hit) begin
          w_next    = ST_DONE;
          w_cap_en  = 1'b1;
          w_cap_exc = EXC_TIMEOUT;
        end
      end
      ST_DONE:  w_next = ST_IDLE;
      ST_DRAIN: if (md_ready | w_hit) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_op_div   <= 1'b0;
      r_rd       <= '0;
      r_md_mult  <= 1'b0;
      r_md_div   <= 1'b0;
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
      r_wb_exc   <= '0;
    end else begin
      r_state    <= w_next;
      r_md_mult  <= w_issue & ~w_op_div;
      r_md_div   <= w_issue & w_op_div;
      r_wb_valid <= w_cap_en;
      if (w_issue) begin
        r_op_div <= w_op_div;
        r_rd     <= ex_rd;
      end
      if (w_cap_en) begin
        r_wb_rd   <= r_rd;
        r_wb_data <= w_cap_data;
        r_wb_exc  <= w_cap_exc;
      end
    end
  end

  // Stall drops in DONE so the pipeline advances alongside the wb strobe;
  // gated by reset so every output reads 0 while reset is held.
  assign stall = reset_n & (w_issue | (r_state == ST_START) | (r_state == ST_WAIT) |
                            ((r_state == ST_DRAIN) & ex_valid & w_is_md));

  assign busy         = (r_state != ST_IDLE);
  assign md_mult      = r_md_mult;
  assign md_div       = r_md_div;
  assign wb_valid     = r_wb_valid;
  assign wb_rd        = r_wb_rd;
  assign wb_data      = r_wb_data;
  assign wb_exc_code  = r_wb_exc;
  assign dbg_state    = r_state;
  assign dbg_wait_cnt = w_count;

endmodule
